// File: rtl/minisrc_pkg.sv
// Shared definitions for the datapath slice: divider FSM states,
// ALU opcodes and the fixed divide latency.
package minisrc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIX,
      DONE
   } div_state_t;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_DIV = 4'd4;
   localparam logic [3:0] ALU_MUL = 4'd5;
   localparam logic [3:0] ALU_SHL = 4'd6;
   localparam logic [3:0] ALU_SHR = 4'd7;

   localparam int DIV_WIDTH   = 32;
   // cycles from the accepting edge through the done cycle
   localparam int DIV_LATENCY = DIV_WIDTH + 2;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational non-restoring divide iteration.
// Ports: r/q/d in (partial remainder, quotient, divisor), r_nxt/q_nxt out.
module div_step
   import minisrc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH:0]   d,
   output logic [WIDTH:0]   r_nxt,
   output logic [WIDTH-1:0] q_nxt
);

   logic [WIDTH:0] r_sh;

   assign r_sh = {r[WIDTH-1:0], q[WIDTH-1]};

   always_comb begin
      r_nxt = r[WIDTH] ? (r_sh + d) : (r_sh - d);
      q_nxt = {q[WIDTH-2:0], ~r_nxt[WIDTH]};
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed divider, C = {remainder, quotient}.
// Ports: clock, clear_n, start, A, B in; busy, done, div_by_zero, C out.
// Optional macro SEQ_DIV_UNSIGNED_EN adds is_unsigned (sampled with start).
module seq_divider
   import minisrc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clock,
   input  logic               clear_n,
   input  logic               start,
`ifdef SEQ_DIV_UNSIGNED_EN
   input  logic               is_unsigned,
`endif
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic [2*WIDTH-1:0] C
);

   div_state_t state, state_nxt;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   r, d, r_nxt;
   logic [WIDTH-1:0] q, q_nxt, a_raw;
   logic             q_neg, r_neg, zdiv;

   logic             uns, a_sgn, b_sgn, b_zero;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] rem_mag, quo, rem;

`ifdef SEQ_DIV_UNSIGNED_EN
   assign uns = is_unsigned;
`else
   assign uns = 1'b0;
`endif

   assign a_sgn  = A[WIDTH-1] & ~uns;
   assign b_sgn  = B[WIDTH-1] & ~uns;
   assign b_zero = (B == '0);
   // -2^(W-1) maps onto itself, which is the correct unsigned magnitude
   assign a_mag  = a_sgn ? (~A + 1'b1) : A;
   assign b_mag  = b_sgn ? (~B + 1'b1) : B;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r     (r),
      .q     (q),
      .d     (d),
      .r_nxt (r_nxt),
      .q_nxt (q_nxt)
   );

   // final remainder is in [0, d), so the low WIDTH bits suffice
   assign rem_mag = r[WIDTH-1:0] + (r[WIDTH] ? d[WIDTH-1:0] : '0);
   assign quo     = q_neg ? (~q + 1'b1) : q;
   assign rem     = r_neg ? (~rem_mag + 1'b1) : rem_mag;

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            // divide by zero passes through FIX so C updates with done
            if (start)
               state_nxt = b_zero ? FIX : ITER;
         end
         ITER: begin
            busy = 1'b1;
            if (cnt == '0)
               state_nxt = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state       <= IDLE;
         cnt         <= '0;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         a_raw       <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         zdiv        <= 1'b0;
         div_by_zero <= 1'b0;
         C           <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (start) begin
                  div_by_zero <= 1'b0;
                  zdiv        <= b_zero;
                  a_raw       <= A;
                  r           <= '0;
                  q           <= a_mag;
                  d           <= {1'b0, b_mag};
                  q_neg       <= a_sgn ^ b_sgn;
                  r_neg       <= a_sgn;
                  cnt         <= CNT_W'(WIDTH - 1);
               end
            end
            ITER: begin
               r <= r_nxt;
               q <= q_nxt;
               if (cnt != '0)
                  cnt <= cnt - 1'b1;
            end
            FIX: begin
               if (zdiv) begin
                  C           <= {a_raw, {WIDTH{1'b1}}};
                  div_by_zero <= 1'b1;
               end else begin
                  C <= {rem, quo};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
